// File: rtl/decode_stage.sv
// decode_stage: RV32/RV64 instruction decode with a two-entry output buffer.
//
// Each instruction is decoded in the cycle it is accepted. The decoded entry
// lands in a main/skid register pair, so the stage can take one extra
// instruction after the downstream stalls. Entries leave in FIFO order.
//
// Parameters: XLEN (32 or 64) sets the immediate width; PC_W sets the width of
//             the PC that travels with each entry.
// Ports:      CLK, RST (synchronous, active-high), FLUSH (drop all entries)
//             IN_VALID/IN_READY/IN_INSTR/IN_PC   upstream handshake and payload
//             OUT_VALID/OUT_READY                downstream handshake
//             OUT_PC, OUT_RS1/RS2/RD, OUT_IMM, OUT_CTRL, OUT_MULDIV, OUT_ILLEGAL
// OUT_CTRL = {JUMP, BR_TYPE[2:0], BRANCH, IMM_SEL[2:0], SIGN, BYTE_SEL[1:0],
//             MEM_READ, MEM_WRITE, REG_WRITE, ALU_FUN[3:0], SRC_B_SEL[1:0],
//             SRC_A_SEL, RF_SEL[1:0]}
// Build option: define DECODE_STAGE_MEXT_EN to decode the M extension
//               (OP with funct7=0000001); otherwise those encodings are illegal.
//
// state | meaning
// EMPTY | no entry held; OUT_VALID low
// ONE   | main register holds the head entry
// FULL  | main holds the head, skid holds the next; IN_READY low

module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     IN_INSTR,
  input  logic [PC_W-1:0] IN_PC,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [PC_W-1:0] OUT_PC,
  output logic [4:0]      OUT_RS1,
  output logic [4:0]      OUT_RS2,
  output logic [4:0]      OUT_RD,
  output logic [XLEN-1:0] OUT_IMM,
  output logic [22:0]     OUT_CTRL,
  output logic            OUT_MULDIV,
  output logic            OUT_ILLEGAL
);

`ifdef DECODE_STAGE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [22:0]     ctrl;
    logic            muldiv;
    logic            illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = IN_INSTR[6:0];
  assign f3     = IN_INSTR[14:12];
  assign f7     = IN_INSTR[31:25];

  // ---------------------------------------------------------------- decode
  logic       jump, branch, sign, mem_read, mem_write, reg_write, src_a_sel;
  logic       muldiv, illegal, sh_zero, sh_arith;
  logic [2:0] br_type, imm_sel;
  logic [1:0] byte_sel, src_b_sel, rf_sel;
  logic [3:0] alu_fun;
  entry_t     dec;

  always_comb begin
    jump = 1'b0; branch = 1'b0; sign = 1'b0; mem_read = 1'b0;
    mem_write = 1'b0; reg_write = 1'b0; src_a_sel = 1'b0;
    muldiv = 1'b0; illegal = 1'b0;
    br_type = 3'b000; imm_sel = 3'b000; byte_sel = 2'b00;
    src_b_sel = 2'b00; rf_sel = 2'b00; alu_fun = 4'b0000;
    dec = '0;

    // Shift-immediate funct field: RV64 uses a 6-bit shamt, so only [31:26]
    // qualifies the op there; on RV32 instr[25] must also be clear.
    if (XLEN == 64) begin
      sh_zero  = (IN_INSTR[31:26] == 6'b000000);
      sh_arith = (IN_INSTR[31:26] == 6'b010000);
    end else begin
      sh_zero  = (f7 == 7'b0000000);
      sh_arith = (f7 == 7'b0100000);
    end

    case (opcode)
      OPC_LUI: begin
        alu_fun = 4'b1001; src_a_sel = 1'b1; rf_sel = 2'b11;
        imm_sel = 3'b011; reg_write = 1'b1;
        dec.imm = XLEN'($signed({IN_INSTR[31:12], 12'h000}));
      end
      OPC_AUIPC: begin
        src_a_sel = 1'b1; src_b_sel = 2'b10; rf_sel = 2'b11; reg_write = 1'b1;
        dec.imm = XLEN'($signed({IN_INSTR[31:12], 12'h000}));
      end
      OPC_JAL: begin
        imm_sel = 3'b100; jump = 1'b1; reg_write = 1'b1;
        dec.imm = XLEN'($signed({IN_INSTR[31], IN_INSTR[19:12], IN_INSTR[20],
                                 IN_INSTR[30:21], 1'b0}));
      end
      OPC_JALR: begin
        src_b_sel = 2'b01; jump = 1'b1; reg_write = 1'b1;
        illegal = (f3 != 3'b000);
        dec.imm = XLEN'($signed(IN_INSTR[31:20]));
      end
      OPC_LOAD: begin
        mem_read = 1'b1; reg_write = 1'b1; rf_sel = 2'b10; src_b_sel = 2'b01;
        byte_sel = f3[1:0];
        sign     = ~f3[2];
        illegal  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        dec.imm  = XLEN'($signed(IN_INSTR[31:20]));
      end
      OPC_STORE: begin
        mem_write = 1'b1; src_b_sel = 2'b01; imm_sel = 3'b001;
        byte_sel = f3[1:0];
        illegal  = (f3 >= 3'b011);
        dec.imm  = XLEN'($signed({IN_INSTR[31:25], IN_INSTR[11:7]}));
      end
      OPC_BRANCH: begin
        branch = 1'b1; imm_sel = 3'b010;
        // 000,001 map straight through; 100..111 pack down to 010..101
        br_type = f3[2] ? (f3 - 3'd2) : f3;
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
        dec.imm = XLEN'($signed({IN_INSTR[31], IN_INSTR[7], IN_INSTR[30:25],
                                 IN_INSTR[11:8], 1'b0}));
      end
      OPC_OPIMM: begin
        alu_fun = {IN_INSTR[30] & (f3 == 3'b101), f3};
        src_b_sel = 2'b01; rf_sel = 2'b11; reg_write = 1'b1;
        if (f3 == 3'b001) illegal = ~sh_zero;
        if (f3 == 3'b101) illegal = ~(sh_zero | sh_arith);
        dec.imm = XLEN'($signed(IN_INSTR[31:20]));
      end
      OPC_OP: begin
        rf_sel = 2'b11; reg_write = 1'b1;
        alu_fun = {IN_INSTR[30], f3};
        if (f7 == 7'b0100000) begin
          illegal = (f3 != 3'b000) && (f3 != 3'b101);
        end else if (f7 == 7'b0000001) begin
          muldiv  = MEXT;
          illegal = ~MEXT;
          alu_fun = {1'b0, f3};
        end else if (f7 != 7'b0000000) begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    dec.pc      = IN_PC;
    dec.rs1     = IN_INSTR[19:15];
    dec.rs2     = IN_INSTR[24:20];
    dec.rd      = IN_INSTR[11:7];
    dec.illegal = illegal;
    dec.muldiv  = illegal ? 1'b0 : muldiv;
    dec.ctrl    = illegal ? 23'd0 :
                  {jump, br_type, branch, imm_sel, sign, byte_sel, mem_read,
                   mem_write, reg_write, alu_fun, src_b_sel, src_a_sel, rf_sel};
  end

  // ---------------------------------------------------------------- buffer
  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d;
  logic   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic   accept, pop;

  assign accept = IN_VALID && in_ready_q;
  assign pop    = out_valid_q && OUT_READY;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin main_d = dec; state_d = ONE; end
      ONE: begin
        if (accept && pop)    main_d = dec;
        else if (accept) begin skid_d = dec; state_d = FULL; end
        else if (pop)          state_d = EMPTY;
      end
      FULL: if (pop) begin main_d = skid_q; state_d = ONE; end
      default: state_d = EMPTY;
    endcase
    if (FLUSH) state_d = EMPTY;
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY    = in_ready_q;
  assign OUT_VALID   = out_valid_q;
  assign OUT_PC      = main_q.pc;
  assign OUT_RS1     = main_q.rs1;
  assign OUT_RS2     = main_q.rs2;
  assign OUT_RD      = main_q.rd;
  assign OUT_IMM     = main_q.imm;
  assign OUT_CTRL    = main_q.ctrl;
  assign OUT_MULDIV  = main_q.muldiv;
  assign OUT_ILLEGAL = main_q.illegal;

endmodule
